rr2_request_queue: RTL and testbench

Two-source buffered front end for the 2-request round-robin arbiter. Each source pushes words into its own FIFO. The block drives the arbiter's `requests` from FIFO occupancy and output-slot availability. It takes back the arbiter's combinational `grants`, pops the granted FIFO, and presents the winning word downstream on a registered valid/ready output.

---
 rtl/rr2_request_queue.sv | 149 ++++++++++++++
 tb/tb_rr2_request_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr2_request_queue.sv
// Two-source buffered front end for a 2-request round-robin arbiter: per-source FIFOs feed one registered output slot.
// Optional macro RR2_GRANT_CHECK_EN enables the sticky illegal-grant flag on err.
module rr2_request_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic [1:0]        requests,
    input  logic [1:0]        grants,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] fifo_mem [2][DEPTH];
    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     wr_ptr_d [2];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [AW-1:0]     rd_ptr_d [2];
    logic [CW-1:0]     cnt_q    [2];
    logic [CW-1:0]     cnt_d    [2];
    logic [DATA_W-1:0] in_data  [2];

    logic [1:0]        in_valid;
    logic [1:0]        in_rdy;
    logic [1:0]        push;
    logic [1:0]        req;
    logic [1:0]        g;
    logic              slot_free;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;

    always_comb begin
        in_valid   = {in1_valid, in0_valid};
        in_data[0] = in0_data;
        in_data[1] = in1_data;
        slot_free  = !out_valid_q || out_ready;
        for (int i = 0; i < 2; i++) begin
            in_rdy[i] = (cnt_q[i] < CW'(DEPTH));
            push[i]   = in_valid[i] && in_rdy[i];
            req[i]    = (cnt_q[i] != '0) && slot_free;
        end
    end

`ifdef RR2_GRANT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        g     = grants & req;
        err_d = err_q || (grants == 2'b11) || ((grants & ~req) != 2'b00);
        if (grants == 2'b11) begin
            g = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    always_comb begin
        g = grants & req;
        // A double grant with both requesting resolves in favour of source 0.
        if (g == 2'b11) begin
            g = 2'b01;
        end
    end

    assign err = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(g[i]);
            cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(g[i]);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (g != 2'b00) begin
            out_valid_d = 1'b1;
            out_src_d   = g[1];
            out_data_d  = fifo_mem[g[1]][rd_ptr_q[g[1]]];
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign in0_ready = in_rdy[0];
    assign in1_ready = in_rdy[1];
    assign requests  = req;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr2_request_queue.sv
// Bench for rr2_request_queue: round-robin arbiter model, per-source scoreboards and directed scenarios.
module tb_rr2_request_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic       in0_ready, in1_ready;
    logic [1:0] requests, grants;
    logic       out_valid, out_src, err;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;

    logic       force_en = 1'b0;
    logic [1:0] force_val = 2'b00;
    logic       arb_last;
    logic [1:0] arb_grant;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    int         n_tests = 0;
    int         n_fail = 0;

    rr2_request_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .requests(requests), .grants(grants),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .err(err)
    );

    always #5 clk = ~clk;

    // Reference 2-way round-robin arbiter; history moves only on a grant.
    always_comb begin
        if (requests == 2'b11) arb_grant = arb_last ? 2'b01 : 2'b10;
        else                   arb_grant = requests;
        grants = force_en ? force_val : arb_grant;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) arb_last <= 1'b1;
        else if (!force_en && arb_grant != 2'b00) arb_last <= arb_grant[1];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes seen mid-cycle complete at the following rising edge.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (!rst) begin
            if (in0_valid && in0_ready) sb0.push_back(in0_data);
            if (in1_valid && in1_ready) sb1.push_back(in1_data);
            if (out_valid && out_ready) begin
                if (out_src == 1'b0) begin
                    if (sb0.size() == 0) check_eq("sb0_underflow", 32'(sb0.size()), 32'd1);
                    else begin exp_w = sb0.pop_front(); check_eq("sb0_data", 32'(out_data), 32'(exp_w)); end
                end else begin
                    if (sb1.size() == 0) check_eq("sb1_underflow", 32'(sb1.size()), 32'd1);
                    else begin exp_w = sb1.pop_front(); check_eq("sb1_data", 32'(out_data), 32'(exp_w)); end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        force_en  = 1'b0;
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || out_valid) && k < 30) begin
            step();
            k++;
        end
        check_eq(tag, 32'(k < 30), 32'd1);
    endtask

    task automatic push_held(input logic src, input logic [7:0] d);
        if (src) begin in1_valid = 1'b1; in1_data = d; end
        else     begin in0_valid = 1'b1; in0_data = d; end
        step();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] alt_d [4];
        logic       alt_s [4];
        logic [1:0] alt_r [4];
        alt_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        alt_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        alt_r = '{2'b11, 2'b11, 2'b11, 2'b10};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_src", 32'(out_src), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_in_ready", 32'({in1_ready, in0_ready}), 32'd3);
        check_eq("rst_requests", 32'(requests), 32'd0);
        rst = 1'b0;

        // Single source
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA1;
        step();
        in0_data = 8'hA2;
        check_eq("s1_req_a", 32'(requests), 32'h1);
        check_eq("s1_no_out_yet", 32'(out_valid), 32'd0);
        step();
        in0_valid = 1'b0;
        check_eq("s1_valid_a1", 32'(out_valid), 32'd1);
        check_eq("s1_data_a1", 32'(out_data), 32'hA1);
        check_eq("s1_req_b", 32'(requests), 32'h1);
        step();
        check_eq("s1_data_a2", 32'(out_data), 32'hA2);
        check_eq("s1_src_a2", 32'(out_src), 32'd0);
        check_eq("s1_req_idle", 32'(requests), 32'h0);
        step();
        check_eq("s1_empty", 32'(out_valid), 32'd0);

        // Alternation
        do_reset();
        force_en = 1'b1; force_val = 2'b00;
        in0_valid = 1'b1; in0_data = 8'h10; in1_valid = 1'b1; in1_data = 8'h20;
        step();
        in0_data = 8'h11; in1_data = 8'h21;
        step();
        in0_valid = 1'b0; in1_valid = 1'b0; force_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("alt_req", 32'(requests), 32'(alt_r[i]));
            step();
            check_eq("alt_data", 32'(out_data), 32'(alt_d[i]));
            check_eq("alt_src", 32'(out_src), 32'(alt_s[i]));
        end
        drain("alt_drain");

        // Full / backpressure
        do_reset();
        out_ready = 1'b0;
        force_en = 1'b1; force_val = 2'b00;
        for (int i = 0; i < 4; i++) push_held(1'b1, 8'h31 + 8'(i));
        check_eq("full_ready", 32'(in1_ready), 32'd0);
        check_eq("full_req", 32'(requests), 32'h2);
        in1_valid = 1'b1; in1_data = 8'h35;
        step();
        check_eq("full_hold", 32'(in1_ready), 32'd0);
        in1_valid = 1'b0; force_en = 1'b0;
        step();
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_data", 32'(out_data), 32'h31);
        check_eq("bp_src", 32'(out_src), 32'd1);
        check_eq("bp_req", 32'(requests), 32'h0);
        step();
        step();
        check_eq("bp_stable", 32'(out_data), 32'h31);
        check_eq("bp_req2", 32'(requests), 32'h0);
        out_ready = 1'b1;
        drain("bp_drain");
        for (int i = 0; i < 6; i++) begin
            in1_valid = 1'b1; in1_data = 8'h41 + 8'(i);
            step();
        end
        in1_valid = 1'b0;
        drain("wrap_drain");

        // Simultaneous push/pop
        do_reset();
        force_en = 1'b1; force_val = 2'b00;
        for (int i = 0; i < 3; i++) push_held(1'b0, 8'hB0 + 8'(i));
        check_eq("pp_cnt_pre", 32'(dut.cnt_q[0]), 32'd3);
        force_en = 1'b0;
        in0_valid = 1'b1; in0_data = 8'hB3;
        check_eq("pp_req", 32'(requests), 32'h1);
        step();
        in0_valid = 1'b0;
        check_eq("pp_cnt", 32'(dut.cnt_q[0]), 32'd3);
        check_eq("pp_ready", 32'(in0_ready), 32'd1);
        check_eq("pp_data", 32'(out_data), 32'hB0);
        drain("pp_drain");

        // Reset mid-traffic
        do_reset();
        out_ready = 1'b0;
        force_en = 1'b1; force_val = 2'b00;
        in0_valid = 1'b1; in0_data = 8'hE0; in1_valid = 1'b1; in1_data = 8'hF0;
        step();
        in0_data = 8'hE1; in1_data = 8'hF1;
        step();
        in0_valid = 1'b0; in1_valid = 1'b0; force_en = 1'b0;
        step();
        check_eq("mr_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        #1;
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        check_eq("mr_req", 32'(requests), 32'h0);
        check_eq("mr_cnt0", 32'(dut.cnt_q[0]), 32'd0);
        check_eq("mr_cnt1", 32'(dut.cnt_q[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("mr_no_stale", 32'(out_valid), 32'd0);
        end

        // Illegal grant
        do_reset();
        out_ready = 1'b1;
        force_en = 1'b1; force_val = 2'b00;
        in0_valid = 1'b1; in0_data = 8'hC0; in1_valid = 1'b1; in1_data = 8'hD0;
        step();
        in0_valid = 1'b0; in1_valid = 1'b0;
        check_eq("ig_req", 32'(requests), 32'h3);
        force_val = 2'b11;
        step();
        force_en = 1'b0; force_val = 2'b00;
`ifdef RR2_GRANT_CHECK_EN
        check_eq("ig_err", 32'(err), 32'd1);
        check_eq("ig_no_pop", 32'(out_valid), 32'd0);
        check_eq("ig_cnt0", 32'(dut.cnt_q[0]), 32'd1);
        drain("ig_drain");
        check_eq("ig_err_sticky", 32'(err), 32'd1);
`else
        check_eq("ig_err", 32'(err), 32'd0);
        check_eq("ig_valid", 32'(out_valid), 32'd1);
        check_eq("ig_data", 32'(out_data), 32'hC0);
        check_eq("ig_src", 32'(out_src), 32'd0);
        drain("ig_drain");
        check_eq("ig_err_end", 32'(err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
